// File: rtl/print_host.sv
// print_host
// ----------
// Bridges a byte-wide character stream onto a simple 32-bit memory-mapped
// write port, as used by a memory-mapped print peripheral. Characters are
// buffered in a small FIFO. A three-state FSM (IDLE / ISSUE / WAIT) drains
// the FIFO one character per write transaction.
//
// Parameters
//   BASE_ADDR : byte address driven on print_addr
//   DEPTH     : character FIFO entries (power of two, >= 2)
//   TIMEOUT   : maximum WAIT cycles before giving up on print_ready
//
// Optional feature
//   PRINT_HOST_TIMEOUT_EN : when defined, WAIT is bounded by TIMEOUT cycles.
//                           An expiry sets the sticky err flag and drops the
//                           character. When undefined, WAIT lasts until
//                           print_ready, and err is tied low.
//
// Ports
//   clock, reset        : rising-edge clock, asynchronous active-high reset
//   char_valid/char_data/char_ready : character input handshake
//   print_valid         : one-cycle write strobe (registered)
//   print_instr         : always 0 (data access)
//   print_addr          : always BASE_ADDR
//   print_wdata         : {24'b0, character} (registered)
//   print_wstrb         : 4'b0001 while print_valid, else 0 (registered)
//   print_rdata         : unused read data
//   print_ready         : completion of the outstanding write
//   busy                : FIFO non-empty or FSM not idle
//   err                 : sticky timeout flag

module print_host #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 8,
  parameter int          TIMEOUT   = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  output logic        char_ready,
  output logic        print_valid,
  output logic        print_instr,
  output logic [31:0] print_addr,
  output logic [31:0] print_wdata,
  output logic [3:0]  print_wstrb,
  input  logic [31:0] print_rdata,
  input  logic        print_ready,
  output logic        busy,
  output logic        err
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          timeout_hit;
  logic          next_valid;
  logic [3:0]    next_wstrb;

  // The read data bus carries nothing this block needs.
  logic unused_rdata;
  assign unused_rdata = ^print_rdata;

  // Full is judged from the registered count only. A pop in the same cycle
  // does not reopen the FIFO, so char_ready never depends on the FSM.
  assign fifo_empty = (count == '0);
  assign char_ready = (count != FULL_COUNT);
  assign push       = char_valid && char_ready;

  assign busy        = !fifo_empty || (state != IDLE);
  assign print_instr = 1'b0;
  assign print_addr  = BASE_ADDR;

  // Character storage. It has no reset because stale entries are
  // unreachable once the pointers and count are cleared.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= char_data;
    end
  end

  // FIFO bookkeeping. The pointers are exactly log2(DEPTH) bits wide,
  // so they wrap modulo DEPTH by themselves. A simultaneous push and pop
  // leaves the count untouched.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. The FIFO is popped whenever the FSM moves into ISSUE.
  // The head byte is captured into print_wdata on the same edge. Leaving
  // WAIT with the FIFO non-empty goes straight back to ISSUE, which gives
  // one character every two cycles against a peripheral that answers in
  // one cycle. print_ready is only looked at in WAIT.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        next_state = WAIT;
      end
      WAIT: begin
        if (print_ready || timeout_hit) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            next_state = ISSUE;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Output decode. Values are computed one cycle ahead from next_state so
  // that the registered strobe lines up exactly with the ISSUE cycle.
  always_comb begin
    next_valid = (next_state == ISSUE);
    next_wstrb = next_valid ? 4'b0001 : 4'b0000;
  end

  // Registered print port. Reset clears the captured character so that a
  // dropped transaction leaves nothing visible on the bus.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      print_valid <= 1'b0;
      print_wstrb <= 4'b0000;
      print_wdata <= 32'h0;
    end else begin
      print_valid <= next_valid;
      print_wstrb <= next_wstrb;
      if (pop) begin
        print_wdata <= {24'h0, mem[rd_ptr]};
      end
    end
  end

`ifdef PRINT_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wait_cnt;
  logic          err_q;

  // The count is the number of WAIT cycles already spent on this write.
  // It expires on the TIMEOUT-th cycle. A ready arriving in that same
  // cycle takes precedence, so the write still counts as successful.
  assign timeout_hit = (state == WAIT) && !print_ready &&
                       (wait_cnt == TW'(TIMEOUT - 1));
  assign err         = err_q;

  // WAIT cycle counter. It restarts every time the FSM enters WAIT.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if ((state == WAIT) && (next_state == WAIT)) begin
      wait_cnt <= wait_cnt + TW'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // Sticky error flag. Only reset clears it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (timeout_hit) begin
      err_q <= 1'b1;
    end
  end
`else
  // Without the timeout, TIMEOUT has no effect on the logic.
  logic unused_cfg;
  assign unused_cfg  = (TIMEOUT == 0);
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_print_host.sv
// tb_print_host
// -------------
// Self-checking bench for print_host. Directed scenarios cover reset,
// single character, ignored ready, back-to-back, backpressure and reset in
// WAIT. A randomized run compares the DUT against a transaction-level model:
// a queue of accepted characters plus counts of accepted, issued and
// completed writes. With PRINT_HOST_TIMEOUT_EN defined, a second instance
// with TIMEOUT=4 exercises the timeout path.

module tb_print_host;

  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h4000_1000;

  logic        clock;
  logic        reset;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic        print_valid;
  logic        print_instr;
  logic [31:0] print_addr;
  logic [31:0] print_wdata;
  logic [3:0]  print_wstrb;
  logic [31:0] print_rdata;
  logic        print_ready;
  logic        busy;
  logic        err;

  int checks = 0;
  int passes = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  print_host #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .TIMEOUT(1000)) dut (
    .clock(clock), .reset(reset),
    .char_valid(char_valid), .char_data(char_data), .char_ready(char_ready),
    .print_valid(print_valid), .print_instr(print_instr),
    .print_addr(print_addr), .print_wdata(print_wdata),
    .print_wstrb(print_wstrb), .print_rdata(print_rdata),
    .print_ready(print_ready), .busy(busy), .err(err)
  );

`ifdef PRINT_HOST_TIMEOUT_EN
  logic        t_reset;
  logic        t_char_valid;
  logic [7:0]  t_char_data;
  logic        t_char_ready;
  logic        t_print_valid;
  logic        t_print_instr;
  logic [31:0] t_print_addr;
  logic [31:0] t_print_wdata;
  logic [3:0]  t_print_wstrb;
  logic        t_print_ready;
  logic        t_busy;
  logic        t_err;

  print_host #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .TIMEOUT(4)) dut_to (
    .clock(clock), .reset(t_reset),
    .char_valid(t_char_valid), .char_data(t_char_data), .char_ready(t_char_ready),
    .print_valid(t_print_valid), .print_instr(t_print_instr),
    .print_addr(t_print_addr), .print_wdata(t_print_wdata),
    .print_wstrb(t_print_wstrb), .print_rdata(print_rdata),
    .print_ready(t_print_ready), .busy(t_busy), .err(t_err)
  );
`endif

  // Advance to one time unit after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    char_valid  = 1'b0;
    char_data   = 8'h00;
    print_ready = 1'b0;
    print_rdata = $urandom;
    tick();
    checks++; if (print_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", print_valid); else passes++;
    checks++; if (print_wstrb !== 4'b0000) $display("[TB] FAIL reset_wstrb: got %b expected 0000", print_wstrb); else passes++;
    checks++; if (print_wdata !== 32'h0) $display("[TB] FAIL reset_wdata: got %h expected 00000000", print_wdata); else passes++;
    checks++; if (err !== 1'b0) $display("[TB] FAIL reset_err: got %b expected 0", err); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passes++;
    tick();
    reset = 1'b0;
    #1;
    checks++; if (char_ready !== 1'b1) $display("[TB] FAIL reset_char_ready: got %b expected 1", char_ready); else passes++;
    checks++; if (print_addr !== BASE) $display("[TB] FAIL reset_addr: got %h expected %h", print_addr, BASE); else passes++;
    checks++; if (print_instr !== 1'b0) $display("[TB] FAIL reset_instr: got %b expected 0", print_instr); else passes++;
  endtask

  task automatic test_single();
    print_ready = 1'b0;
    char_valid  = 1'b1;
    char_data   = 8'h41;
    tick();
    char_valid = 1'b0;
    checks++; if (print_valid !== 1'b0) $display("[TB] FAIL single_latency_e0: got %b expected 0", print_valid); else passes++;
    checks++; if (busy !== 1'b1) $display("[TB] FAIL single_busy_queued: got %b expected 1", busy); else passes++;
    tick();
    checks++; if (print_valid !== 1'b1) $display("[TB] FAIL single_latency_e1: got %b expected 1", print_valid); else passes++;
    checks++; if (print_wdata !== 32'h0000_0041) $display("[TB] FAIL single_wdata: got %h expected 00000041", print_wdata); else passes++;
    checks++; if (print_wstrb !== 4'b0001) $display("[TB] FAIL single_wstrb: got %b expected 0001", print_wstrb); else passes++;
    checks++; if (print_addr !== BASE) $display("[TB] FAIL single_addr: got %h expected %h", print_addr, BASE); else passes++;
    checks++; if (print_instr !== 1'b0) $display("[TB] FAIL single_instr: got %b expected 0", print_instr); else passes++;
    tick();
    checks++; if (print_valid !== 1'b0 || print_wstrb !== 4'b0000) $display("[TB] FAIL single_one_cycle: got valid %b wstrb %b expected 0 0000", print_valid, print_wstrb); else passes++;
    checks++; if (busy !== 1'b1) $display("[TB] FAIL single_busy_wait: got %b expected 1", busy); else passes++;
    print_ready = 1'b1;
    tick();
    print_ready = 1'b0;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL single_busy_done: got %b expected 0", busy); else passes++;
  endtask

  task automatic test_ignore_ready();
    print_ready = 1'b1;
    tick(); tick(); tick();
    checks++; if (busy !== 1'b0 || print_valid !== 1'b0) $display("[TB] FAIL ignore_idle: got busy %b valid %b expected 0 0", busy, print_valid); else passes++;
    print_ready = 1'b0;
    char_valid  = 1'b1;
    char_data   = 8'h33;
    tick();
    char_valid = 1'b0;
    tick();
    checks++; if (print_valid !== 1'b1 || print_wdata !== 32'h33) $display("[TB] FAIL ignore_pulse: got valid %b wdata %h expected 1 00000033", print_valid, print_wdata); else passes++;
    print_ready = 1'b1;
    tick();
    print_ready = 1'b0;
    tick(); tick();
    checks++; if (busy !== 1'b1 || print_valid !== 1'b0) $display("[TB] FAIL ignore_issue_ready: got busy %b valid %b expected 1 0", busy, print_valid); else passes++;
    print_ready = 1'b1;
    tick();
    print_ready = 1'b0;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL ignore_done: got %b expected 0", busy); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] msg [3];
    logic [7:0] got [$];
    int         when [$];
    bit         last_pv;
    msg[0] = 8'h48; msg[1] = 8'h69; msg[2] = 8'h0A;
    last_pv     = 1'b0;
    print_ready = 1'b0;
    char_valid  = 1'b1;
    char_data   = msg[0];
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i + 1 < 3) begin
        char_valid = 1'b1;
        char_data  = msg[i + 1];
      end else begin
        char_valid = 1'b0;
      end
      print_ready = last_pv;
      last_pv     = print_valid;
      if (print_valid) begin
        got.push_back(print_wdata[7:0]);
        when.push_back(i);
      end
    end
    print_ready = 1'b0;
    checks++; if (got.size() != 3) $display("[TB] FAIL b2b_count: got %0d expected 3", got.size()); else passes++;
    for (int k = 0; k < 3 && k < got.size(); k++) begin
      checks++; if (got[k] !== msg[k]) $display("[TB] FAIL b2b_data%0d: got %h expected %h", k, got[k], msg[k]); else passes++;
    end
    for (int k = 1; k < 3 && k < when.size(); k++) begin
      checks++; if (when[k] - when[k-1] != 2) $display("[TB] FAIL b2b_spacing%0d: got %0d expected 2", k, when[k] - when[k-1]); else passes++;
    end
    checks++; if (busy !== 1'b0) $display("[TB] FAIL b2b_idle: got %b expected 0", busy); else passes++;
  endtask

  task automatic test_backpressure();
    logic [7:0] sent [$];
    logic [7:0] got [$];
    int         accepted;
    accepted = 0;
    for (int i = 0; i < DEPTH + 2; i++) sent.push_back(8'(8'h80 + i));
    print_ready = 1'b0;
    for (int c = 0; c < DEPTH + 8; c++) begin
      char_valid = (accepted < DEPTH + 2);
      if (accepted < DEPTH + 2) char_data = sent[accepted];
      if (char_valid && char_ready) accepted++;
      tick();
      if (print_valid) got.push_back(print_wdata[7:0]);
    end
    checks++; if (accepted != DEPTH + 1) $display("[TB] FAIL bp_accepted: got %0d expected %0d", accepted, DEPTH + 1); else passes++;
    checks++; if (char_ready !== 1'b0) $display("[TB] FAIL bp_char_ready: got %b expected 0", char_ready); else passes++;
    checks++; if (got.size() != 1) $display("[TB] FAIL bp_inflight: got %0d expected 1", got.size()); else passes++;
    for (int n = 0; n < 200; n++) begin
      char_valid = (accepted < DEPTH + 2);
      if (accepted < DEPTH + 2) char_data = sent[accepted];
      if (char_valid && char_ready) accepted++;
      print_ready = !print_valid;
      tick();
      if (print_valid) got.push_back(print_wdata[7:0]);
      if (accepted == DEPTH + 2 && got.size() == DEPTH + 2 && !busy) break;
    end
    char_valid  = 1'b0;
    print_ready = 1'b0;
    checks++; if (got.size() != DEPTH + 2) $display("[TB] FAIL bp_total: got %0d expected %0d", got.size(), DEPTH + 2); else passes++;
    for (int k = 0; k < DEPTH + 2 && k < got.size(); k++) begin
      checks++; if (got[k] !== sent[k]) $display("[TB] FAIL bp_order%0d: got %h expected %h", k, got[k], sent[k]); else passes++;
    end
  endtask

  task automatic test_reset_in_wait();
    int pulses;
    bit seen;
    print_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      char_valid = 1'b1;
      char_data  = 8'(8'h11 * (i + 1));
      tick();
    end
    char_valid = 1'b0;
    tick(); tick();
    checks++; if (busy !== 1'b1 || print_valid !== 1'b0) $display("[TB] FAIL rw_pre: got busy %b valid %b expected 1 0", busy, print_valid); else passes++;
    reset = 1'b1;
    #1;
    checks++; if (print_valid !== 1'b0 || print_wstrb !== 4'b0000) $display("[TB] FAIL rw_valid: got valid %b wstrb %b expected 0 0000", print_valid, print_wstrb); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL rw_busy: got %b expected 0", busy); else passes++;
    checks++; if (print_wdata !== 32'h0) $display("[TB] FAIL rw_wdata: got %h expected 00000000", print_wdata); else passes++;
    tick(); tick();
    reset  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      print_ready = 1'($urandom_range(0, 1));
      tick();
      if (print_valid) pulses++;
    end
    print_ready = 1'b0;
    checks++; if (pulses != 0 || busy !== 1'b0) $display("[TB] FAIL rw_silent: got pulses %0d busy %b expected 0 0", pulses, busy); else passes++;
    char_valid = 1'b1;
    char_data  = 8'h7A;
    tick();
    char_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = print_valid;
    end
    checks++; if (!seen || print_wdata !== 32'h7A) $display("[TB] FAIL rw_next: got seen %b wdata %h expected 1 0000007a", seen, print_wdata); else passes++;
    tick();
    print_ready = 1'b1;
    tick();
    print_ready = 1'b0;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL rw_done: got %b expected 0", busy); else passes++;
  endtask

  // Transaction-level model: every accepted byte must come out once, in
  // order. Each write stays outstanding until the peripheral acknowledges
  // it. FIFO occupancy equals bytes accepted minus bytes issued.
  task automatic test_random();
    logic [7:0] exp_q [$];
    logic [7:0] exp_b;
    logic [7:0] pend_data;
    int         accepted, completed, issued, cnt, cyc;
    bit         outstanding, push_pend, ready_pend, prev_pv, pv;
    accepted = 0; completed = 0; issued = 0; cnt = 0; cyc = 0;
    outstanding = 0; push_pend = 0; ready_pend = 0; prev_pv = 0;
    pend_data = 8'h00;
    char_valid  = 1'b0;
    print_ready = 1'b0;
    while (cyc < 3000) begin
      tick();
      cyc++;
      if (push_pend) begin
        accepted++;
        exp_q.push_back(pend_data);
      end
      if (ready_pend) completed++;
      pv = print_valid;
      if (pv) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("[TB] FAIL rnd_data: got %h expected no pulse", print_wdata);
        end else begin
          exp_b = exp_q.pop_front();
          if (print_wdata !== {24'h0, exp_b}) $display("[TB] FAIL rnd_data: got %h expected %h", print_wdata, {24'h0, exp_b}); else passes++;
        end
        checks++; if (prev_pv || print_wstrb !== 4'b0001) $display("[TB] FAIL rnd_pulse: got prev %b wstrb %b expected 0 0001", prev_pv, print_wstrb); else passes++;
        issued++;
        outstanding = 1'b1;
        cnt = $urandom_range(0, 3);
      end else begin
        checks++; if (print_wstrb !== 4'b0000) $display("[TB] FAIL rnd_wstrb_idle: got %b expected 0000", print_wstrb); else passes++;
      end
      checks++; if (busy !== (accepted != completed)) $display("[TB] FAIL rnd_busy: got %b expected %b", busy, accepted != completed); else passes++;
      checks++; if (char_ready !== ((accepted - issued) < DEPTH)) $display("[TB] FAIL rnd_char_ready: got %b expected %b", char_ready, (accepted - issued) < DEPTH); else passes++;
      prev_pv    = pv;
      ready_pend = 1'b0;
      if (pv) begin
        print_ready = 1'b0;
      end else if (outstanding) begin
        if (cnt == 0) begin
          print_ready = 1'b1;
          ready_pend  = 1'b1;
          outstanding = 1'b0;
        end else begin
          cnt--;
          print_ready = 1'b0;
        end
      end else begin
        print_ready = ($urandom_range(0, 7) == 0);
      end
      char_valid = (cyc < 400) ? ($urandom_range(0, 3) != 0) : 1'b0;
      char_data  = 8'($urandom);
      push_pend  = char_valid && char_ready;
      pend_data  = char_data;
      if (cyc >= 400 && !push_pend && accepted == completed && !outstanding) break;
    end
    char_valid  = 1'b0;
    print_ready = 1'b0;
    checks++; if (completed != accepted || exp_q.size() != 0) $display("[TB] FAIL rnd_drain: got completed %0d left %0d expected %0d 0", completed, exp_q.size(), accepted); else passes++;
    checks++; if (accepted < 50) $display("[TB] FAIL rnd_volume: got %0d expected at least 50", accepted); else passes++;
    checks++; if (err !== 1'b0) $display("[TB] FAIL rnd_err: got %b expected 0", err); else passes++;
  endtask

`ifdef PRINT_HOST_TIMEOUT_EN
  task automatic test_timeout();
    int  n;
    bit  seen;
    bit  err_early;
    t_reset       = 1'b1;
    t_char_valid  = 1'b0;
    t_char_data   = 8'h00;
    t_print_ready = 1'b0;
    tick();
    t_reset = 1'b0;
    t_char_valid = 1'b1;
    t_char_data  = 8'h55;
    tick();
    t_char_data = 8'h66;
    tick();
    t_char_valid = 1'b0;
    seen = t_print_valid;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = t_print_valid;
    end
    checks++; if (!seen || t_print_wdata !== 32'h55) $display("[TB] FAIL to_first: got seen %b wdata %h expected 1 00000055", seen, t_print_wdata); else passes++;
    n = 0;
    err_early = 1'b0;
    seen = 1'b0;
    while (n < 20 && !seen) begin
      tick();
      n++;
      if (n == 4) err_early = t_err;
      seen = t_print_valid;
    end
    checks++; if (n != 5) $display("[TB] FAIL to_wait_len: got %0d expected 5", n); else passes++;
    checks++; if (err_early !== 1'b0 || t_err !== 1'b1) $display("[TB] FAIL to_err: got before %b after %b expected 0 1", err_early, t_err); else passes++;
    checks++; if (t_print_wdata !== 32'h66) $display("[TB] FAIL to_second: got %h expected 00000066", t_print_wdata); else passes++;
    for (int i = 0; i < 20 && t_busy; i++) tick();
    checks++; if (t_busy !== 1'b0 || t_err !== 1'b1) $display("[TB] FAIL to_sticky: got busy %b err %b expected 0 1", t_busy, t_err); else passes++;
    t_reset = 1'b1;
    #1;
    checks++; if (t_err !== 1'b0) $display("[TB] FAIL to_reset: got %b expected 0", t_err); else passes++;
    tick();
    t_reset = 1'b0;
  endtask
`endif

  initial begin
`ifdef PRINT_HOST_TIMEOUT_EN
    t_reset       = 1'b1;
    t_char_valid  = 1'b0;
    t_char_data   = 8'h00;
    t_print_ready = 1'b0;
`endif
    $display("[TB] starting print_host bench");
    test_reset();
    test_single();
    test_ignore_ready();
    test_back_to_back();
    test_backpressure();
    test_reset_in_wait();
    test_random();
`ifdef PRINT_HOST_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/print_host.md
PRINT_HOST -- requirements
Module: print_host

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, giving the byte address driven on print_addr.
REQ-002 The block SHALL have parameter DEPTH, default 8, giving character FIFO entries; it SHALL be a power of two, at least 2.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, giving the maximum number of cycles to wait for print_ready.
REQ-004 Port clock, input, 1 bit: the only clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-006 Port char_valid, input, 1 bit: a character is offered.
REQ-007 Port char_data, input, 8 bits: the offered character.
REQ-008 Port char_ready, output, 1 bit: high when the FIFO can accept a character (not full).
REQ-009 Port print_valid, output, 1 bit: write request strobe to the print peripheral.
REQ-010 Port print_instr, output, 1 bit: constant 0 (data access).
REQ-011 Port print_addr, output, 32 bits: constant BASE_ADDR.
REQ-012 Port print_wdata, output, 32 bits: {24'b0, character}.
REQ-013 Port print_wstrb, output, 4 bits: 4'b0001 while print_valid is high, 4'b0000 otherwise.
REQ-014 Port print_rdata, input, 32 bits: ignored.
REQ-015 Port print_ready, input, 1 bit: completion of the outstanding write.
REQ-016 Port busy, output, 1 bit: high when the FIFO is non-empty or the FSM is not IDLE.
REQ-017 Port err, output, 1 bit: sticky timeout flag.

Function
REQ-018 A character SHALL be pushed at a rising edge where char_valid and char_ready are both 1; char_ready SHALL be 0 when the FIFO holds DEPTH entries, even if a pop occurs in the same cycle.
REQ-019 The FIFO SHALL preserve order; simultaneous push and pop SHALL leave the count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-020 The FSM SHALL have states IDLE, ISSUE and WAIT.
REQ-021 IDLE with the FIFO non-empty SHALL pop the head into the wdata register and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-022 In ISSUE, print_valid SHALL be 1 for exactly one cycle, then the FSM SHALL go to WAIT.
REQ-023 In WAIT, print_ready=1 SHALL complete the write; if the FIFO is non-empty, the block SHALL pop and go directly to ISSUE, otherwise it SHALL go to IDLE.
REQ-024 print_valid SHALL never be 1 outside ISSUE; each character SHALL produce exactly one print_valid pulse.
REQ-025 Latency: a character pushed into an empty, idle block at edge E SHALL have print_valid high in the cycle following edge E+1.
REQ-026 Peak throughput SHALL be one character per 2 cycles when the peripheral answers one cycle after print_valid.
REQ-027 print_ready while not in WAIT SHALL be ignored.
REQ-028 All print_* outputs SHALL be registered.

Reset
REQ-029 Asserting reset SHALL immediately force: FSM to IDLE, FIFO empty, print_valid=0, print_wdata=0, print_wstrb=0, err=0, busy=0, and char_ready=1 once reset is released.
REQ-030 A reset during ISSUE or WAIT SHALL drop the outstanding character and all FIFO contents; no further print_valid SHALL be issued until a new push.

Configuration
REQ-031 With PRINT_HOST_TIMEOUT_EN defined, a counter SHALL run in WAIT; after TIMEOUT cycles without print_ready, the block SHALL set err=1 (sticky until reset), drop the character, and continue per REQ-023 as if ready had arrived.
REQ-032 Without PRINT_HOST_TIMEOUT_EN, WAIT SHALL last indefinitely until print_ready, and err SHALL be tied to 0.

Verification
REQ-033 Push 0x41 with the peripheral answering ready one cycle after valid -> one pulse with print_wdata=0x00000041, print_wstrb=4'b0001, print_addr=BASE_ADDR; busy falls after ready.
REQ-034 Push "Hi\n" back-to-back (0x48, 0x69, 0x0A) -> three pulses in order, 2 cycles apart.
REQ-035 Hold print_ready=0 and push DEPTH+2 characters -> char_ready falls after DEPTH+1 accepted (1 in flight plus DEPTH queued); no character is lost or duplicated after ready resumes.
REQ-036 With PRINT_HOST_TIMEOUT_EN and TIMEOUT=4, never assert ready after pushing 0x55 then 0x66 -> err=1 after 4 WAIT cycles; 0x66 is then issued.
REQ-037 Assert reset during WAIT with 3 characters queued -> print_valid=0 immediately; after release, no pulses until a new push, and the next pushed 0x7A is issued first.
